// File: rtl/spi_slave.sv
// SPI slave front-end for a single-port RAM: deserialises {cmd, payload} frames and serialises RAM read data.
// Optional macro SPI_FRAME_ERR_EN adds a frame_err pulse for frames cut short by SS_n.
module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int CNT_W = $clog2(ADDR_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ADDR_SIZE);
  localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     tx_cnt;
  logic [ADDR_SIZE:0]   shift_reg;
  logic [ADDR_SIZE-1:0] tx_shift;
  logic                 frame_done;
  logic                 rd_addr_flag;
  logic                 tx_busy;
  logic                 tx_used;
  logic                 in_frame;
  logic                 last_bit;
  logic                 tx_load;

  always_comb begin
    in_frame   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    last_bit   = in_frame && !SS_n && !frame_done && (bit_cnt == LAST_BIT);
    tx_load    = (state == READ_DATA) && !SS_n && frame_done && !tx_used && tx_valid;
    next_state = state;
    if (SS_n) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)             next_state = WRITE;
          else if (rd_addr_flag) next_state = READ_DATA;
          else                   next_state = READ_ADD;
        end
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Frame capture, read-address tracking and the one-shot TX shifter per READ_DATA frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      bit_cnt      <= '0;
      tx_cnt       <= '0;
      shift_reg    <= '0;
      tx_shift     <= '0;
      frame_done   <= 1'b0;
      rd_addr_flag <= 1'b0;
      tx_busy      <= 1'b0;
      tx_used      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        bit_cnt    <= '0;
        frame_done <= 1'b0;
        MISO       <= 1'b0;
        tx_busy    <= 1'b0;
        tx_used    <= 1'b0;
        tx_cnt     <= '0;
      end else begin
        if (state == CHK_CMD) begin
          shift_reg <= {{ADDR_SIZE{1'b0}}, MOSI};
          bit_cnt   <= '0;
        end else if (in_frame && !frame_done) begin
          shift_reg <= {shift_reg[ADDR_SIZE-1:0], MOSI};
          bit_cnt   <= bit_cnt + CNT_W'(1);
          if (last_bit) begin
            rx_data    <= {shift_reg, MOSI};
            rx_valid   <= 1'b1;
            frame_done <= 1'b1;
            if (state == READ_ADD)  rd_addr_flag <= 1'b1;
            if (state == READ_DATA) rd_addr_flag <= 1'b0;
          end
        end
        if (tx_load) begin
          MISO     <= tx_data[ADDR_SIZE-1];
          tx_shift <= tx_data << 1;
          tx_cnt   <= TX_LAST;
          tx_busy  <= 1'b1;
          tx_used  <= 1'b1;
        end else if (tx_busy) begin
          if (tx_cnt != '0) begin
            MISO     <= tx_shift[ADDR_SIZE-1];
            tx_shift <= tx_shift << 1;
            tx_cnt   <= tx_cnt - CNT_W'(1);
          end else begin
            MISO    <= 1'b0;
            tx_busy <= 1'b0;
          end
        end
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  // Any SS_n release after IDLE but before bit 0 was captured is a truncated frame
  always_ff @(posedge clk) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= SS_n && (state != IDLE) && !frame_done;
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed scenarios plus random frames against a frame-level reference model.
// Build with SPI_FRAME_ERR_EN defined to also check frame_err.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  typedef enum {M_WRITE, M_RD_ADD, M_RD_DATA} mode_t;

  // Reference model: whether a read address is pending, and what rx_data should hold
  bit         model_rd_flag = 1'b0;
  logic [9:0] model_rx      = '0;

  always #5 clk = ~clk;

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkFrameErr(input logic expected);
`ifdef SPI_FRAME_ERR_EN
    checkOutput("frame_err", 16'(frame_err), 16'(expected));
`else
    if (expected) ;
`endif
  endtask

  // Sends one complete frame and checks the strobe; returns the mode the model predicts
  task automatic applyStimulus(input logic [9:0] frame, output mode_t mode);
    mode = !frame[9] ? M_WRITE : (model_rd_flag ? M_RD_DATA : M_RD_ADD);
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = frame[i];
      tick();
      checkOutput(i == 0 ? "rx_valid_strobe" : "rx_valid_quiet", 16'(rx_valid), 16'(i == 0));
      checkOutput("miso_in_frame", 16'(MISO), 16'(0));
    end
    checkOutput("rx_data", 16'(rx_data), 16'(frame));
    model_rx = frame;
    if (mode == M_RD_ADD)  model_rd_flag = 1'b1;
    if (mode == M_RD_DATA) model_rd_flag = 1'b0;
    MOSI = 1'($urandom);
    tick();
    checkOutput("rx_valid_drop", 16'(rx_valid), 16'(0));
  endtask

  task automatic txPhase(input mode_t mode, input logic [7:0] data, input int delay);
    for (int d = 0; d < delay; d++) begin
      tick();
      checkOutput("miso_wait_tx", 16'(MISO), 16'(0));
    end
    tx_valid = 1'b1;
    tx_data  = data;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    for (int k = 7; k >= 0; k--) begin
      checkOutput("miso_bit", 16'(MISO), 16'((mode == M_RD_DATA) ? data[k] : 1'b0));
      tick();
    end
    checkOutput("miso_after_tx", 16'(MISO), 16'(0));
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checkOutput("miso_second_tx_ignored", 16'(MISO), 16'(0));
    tick();
    checkOutput("miso_second_tx_ignored", 16'(MISO), 16'(0));
  endtask

  task automatic endFrame();
    for (int j = 0; j < 3; j++) begin
      MOSI = 1'($urandom);
      tick();
      checkOutput("hold_no_strobe", 16'(rx_valid), 16'(0));
      checkOutput("hold_miso", 16'(MISO), 16'(0));
    end
    SS_n = 1'b1;
    tick();
    checkOutput("idle_miso", 16'(MISO), 16'(0));
    checkOutput("idle_rx_valid", 16'(rx_valid), 16'(0));
    checkOutput("rx_data_hold", 16'(rx_data), 16'(model_rx));
    checkFrameErr(1'b0);
  endtask

  // Releases SS_n after nbits frame bits (0 = abort while the command bit is due)
  task automatic abortFrame(input logic [9:0] frame, input int nbits);
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick();
    for (int i = 0; i < nbits; i++) begin
      MOSI = frame[9-i];
      tick();
      checkOutput("abort_no_strobe", 16'(rx_valid), 16'(0));
    end
    SS_n = 1'b1;
    MOSI = frame[9-nbits];
    tick();
    checkOutput("abort_no_strobe", 16'(rx_valid), 16'(0));
    checkOutput("abort_rx_data_hold", 16'(rx_data), 16'(model_rx));
    checkFrameErr(1'b1);
    tick();
    checkFrameErr(1'b0);
    checkOutput("abort_miso", 16'(MISO), 16'(0));
  endtask

  initial begin
    mode_t m;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    tick();
    tick();
    checkOutput("reset_rx_valid", 16'(rx_valid), 16'(0));
    checkOutput("reset_rx_data", 16'(rx_data), 16'(0));
    checkOutput("reset_miso", 16'(MISO), 16'(0));
    checkFrameErr(1'b0);
    rst_n = 1'b1;
    tick();

    $display("[TB] write frame");
    applyStimulus(10'h005, m);
    txPhase(m, 8'h3C, 0);
    endFrame();

    $display("[TB] read address then read data");
    applyStimulus(10'h205, m);
    txPhase(m, 8'h5A, 1);
    endFrame();
    applyStimulus(10'h3C7, m);
    checkOutput("rx_cmd_read_data", 16'(rx_data[9:8]), 16'(2'b11));
    txPhase(m, 8'hA5, 2);
    endFrame();

    $display("[TB] read flag alternation");
    applyStimulus(10'h2AA, m);
    txPhase(m, 8'hC3, 0);
    endFrame();
    applyStimulus(10'h311, m);
    txPhase(m, 8'h81, 0);
    endFrame();
    applyStimulus(10'h200, m);
    txPhase(m, 8'hFF, 0);
    endFrame();

    $display("[TB] aborted frames");
    abortFrame(10'h0F3, 5);
    abortFrame(10'h3FF, 9);
    abortFrame(10'h2FF, 0);

    $display("[TB] abort during tx shifting");
    applyStimulus(10'h3C3, m);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    checkOutput("abort_tx_bit7", 16'(MISO), 16'(m == M_RD_DATA));
    tick();
    checkOutput("abort_tx_bit6", 16'(MISO), 16'(m == M_RD_DATA));
    SS_n = 1'b1;
    tick();
    checkOutput("abort_tx_miso", 16'(MISO), 16'(0));
    checkFrameErr(1'b0);
    applyStimulus(10'h201, m);
    txPhase(m, 8'h77, 0);
    endFrame();

    $display("[TB] reset during tx shifting");
    applyStimulus(10'h3AB, m);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_miso", 16'(MISO), 16'(m == M_RD_DATA));
    rst_n = 1'b0;
    tick();
    checkOutput("reset_tx_miso", 16'(MISO), 16'(0));
    checkOutput("reset_tx_rx_valid", 16'(rx_valid), 16'(0));
    checkOutput("reset_tx_rx_data", 16'(rx_data), 16'(0));
    model_rd_flag = 1'b0;
    model_rx      = '0;
    rst_n = 1'b1;
    SS_n  = 1'b1;
    tick();
    applyStimulus(10'h2F0, m);
    txPhase(m, 8'hE7, 0);
    endFrame();
    applyStimulus(10'h3F0, m);
    txPhase(m, 8'h96, 1);
    endFrame();

    $display("[TB] random frames");
    for (int n = 0; n < 40; n++) begin
      logic [9:0] frame;
      frame = 10'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        abortFrame(frame, int'($urandom_range(0, 9)));
      end else begin
        applyStimulus(frame, m);
        if ($urandom_range(0, 3) != 0)
          txPhase(m, 8'($urandom), int'($urandom_range(0, 3)));
        endFrame();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
